// File: rtl/sarray_pkg.sv
// Shared widths and the writeback FSM state type for the systolic-array store path.
package sarray_pkg;

    localparam int ADDR_WIDTH         = 64;
    localparam int SARRAY_STORE_WIDTH = 256;
    localparam int TMMA_CNT_WIDTH     = 8;
    localparam int SARRAY_ROWS        = 16;
    localparam int SARRAY_ROW_SHIFT   = 8;

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        DONE
    } wb_state_t;

endpackage

// File: rtl/sarray_wb_fifo.sv
// Synchronous row FIFO with a registered head; the pointers and occupancy are reset, the storage is not.
module sarray_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sarray_store_wb.sv
// Store-writeback stage: buffers array result rows and issues one addressed write per row.
// Optional tile-tag checking is enabled with the SARRAY_WB_TAG_CHECK_EN macro.
module sarray_store_wb
    import sarray_pkg::*;
#(
    parameter int ADDR_WIDTH = sarray_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = SARRAY_STORE_WIDTH,
    parameter int CNT_WIDTH  = TMMA_CNT_WIDTH,
    parameter int ROWS       = SARRAY_ROWS,
    parameter int ROW_SHIFT  = SARRAY_ROW_SHIFT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [ADDR_WIDTH-1:0] cfg_dst_i,
    input  logic [CNT_WIDTH-1:0]  cfg_cnt_i,
    input  logic                  row_valid_i,
    output logic                  row_ready_o,
    input  logic [CNT_WIDTH-1:0]  row_cnt_i,
    input  logic [DATA_WIDTH-1:0] row_data_i,
    output logic                  aw_valid_o,
    input  logic                  aw_ready_i,
    output logic [ADDR_WIDTH-1:0] aw_addr_o,
    output logic [DATA_WIDTH-1:0] aw_data_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int IN_W  = $clog2(ROWS + 1);
    localparam int OUT_W = $clog2(ROWS);

    wb_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [IN_W-1:0]       in_idx_q, in_idx_d;
    logic [OUT_W-1:0]      out_idx_q, out_idx_d;

    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  cfg_fire, push, pop, last_row;

    assign cfg_ready_o = (state_q == IDLE);
    assign cfg_fire    = cfg_valid_i & cfg_ready_o;
    assign row_ready_o = (state_q == STORE) & ~fifo_full & (in_idx_q < IN_W'(ROWS));
    assign push        = row_valid_i & row_ready_o;
    assign aw_valid_o  = (state_q == STORE) & ~fifo_empty;
    assign pop         = aw_valid_o & aw_ready_i;
    assign last_row    = (out_idx_q == OUT_W'(ROWS - 1));
    assign done_o      = (state_q == DONE);

    // Address and data read as zero whenever no write is being offered.
    assign aw_addr_o = aw_valid_o ? base_q + (ADDR_WIDTH'(out_idx_q) << ROW_SHIFT) : '0;
    assign aw_data_o = aw_valid_o ? fifo_head : '0;

    sarray_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (row_data_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        in_idx_d  = in_idx_q;
        out_idx_d = out_idx_q;
        case (state_q)
            IDLE: begin
                if (cfg_fire) begin
                    state_d   = STORE;
                    base_d    = cfg_dst_i;
                    in_idx_d  = '0;
                    out_idx_d = '0;
                end
            end
            STORE: begin
                if (push) in_idx_d = in_idx_q + 1'b1;
                if (pop) begin
                    out_idx_d = out_idx_q + 1'b1;
                    if (last_row) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_idx_q  <= '0;
            out_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        base_q <= base_d;
    end

`ifdef SARRAY_WB_TAG_CHECK_EN
    logic [CNT_WIDTH-1:0] tag_q;
    logic                 err_q;

    always_ff @(posedge clk) begin
        if (cfg_fire) tag_q <= cfg_cnt_i;
    end

    // A mismatching row is still written; the flag only records it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (push && (row_cnt_i != tag_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_tags;

    assign unused_tags = ^{row_cnt_i, cfg_cnt_i};
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_sarray_store_wb.sv
// Scoreboard bench for sarray_store_wb: rows queue expected writes, aw handshakes pop and compare.
module tb_sarray_store_wb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid_i = 1'b0;
    logic         cfg_ready_o;
    logic [63:0]  cfg_dst_i = '0;
    logic [7:0]   cfg_cnt_i = '0;
    logic         row_valid_i = 1'b0;
    logic         row_ready_o;
    logic [7:0]   row_cnt_i = '0;
    logic [255:0] row_data_i = '0;
    logic         aw_valid_o;
    logic         aw_ready_i = 1'b1;
    logic [63:0]  aw_addr_o;
    logic [255:0] aw_data_o;
    logic         done_o;
    logic         err_o;

    sarray_store_wb dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_dst_i   (cfg_dst_i),
        .cfg_cnt_i   (cfg_cnt_i),
        .row_valid_i (row_valid_i),
        .row_ready_o (row_ready_o),
        .row_cnt_i   (row_cnt_i),
        .row_data_i  (row_data_i),
        .aw_valid_o  (aw_valid_o),
        .aw_ready_i  (aw_ready_i),
        .aw_addr_o   (aw_addr_o),
        .aw_data_o   (aw_data_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  addr;
        logic [255:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] aw_log[$];
    logic [63:0] tb_base;
    int          tb_in, tb_out, done_cnt;
    logic        exp_done, prev_hold;
    logic [63:0] prev_addr;
    logic [255:0] prev_data;
    logic [7:0]  cur_tag;
    int          n_run, n_fail;

`ifdef SARRAY_WB_TAG_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: tracks tile base and row indices from observed handshakes.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_done  = 1'b0;
            prev_hold = 1'b0;
            tb_in     = 0;
            tb_out    = 0;
        end else begin
            chk("done_pulse", done_o, exp_done);
            if (done_o) done_cnt++;
            exp_done = 1'b0;
            if (prev_hold) begin
                chk("aw_hold_valid", aw_valid_o, 1'b1);
                chk("aw_hold_addr", aw_addr_o, prev_addr);
                chk("aw_hold_data", aw_data_o, prev_data);
            end
            if (cfg_valid_i && cfg_ready_o) begin
                tb_base = cfg_dst_i;
                tb_in   = 0;
                tb_out  = 0;
                aw_log.delete();
            end
            if (row_valid_i && row_ready_o) begin
                exp_t e;
                chk("row_in_range", tb_in < 16, 1'b1);
                e.addr = tb_base + (64'(tb_in) << 8);
                e.data = row_data_i;
                exp_q.push_back(e);
                tb_in++;
            end
            if (aw_valid_o && aw_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("aw_unexpected", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("aw_addr", aw_addr_o, e.addr);
                    chk("aw_data", aw_data_o, e.data);
                end
                aw_log.push_back(aw_addr_o);
                if (tb_out == 15) exp_done = 1'b1;
                tb_out++;
            end
            prev_hold = aw_valid_o && !aw_ready_i;
            prev_addr = aw_addr_o;
            prev_data = aw_data_o;
        end
    end

    task automatic do_cfg(input logic [63:0] dst, input logic [7:0] cnt);
        logic hs = 1'b0;
        cfg_valid_i = 1'b1;
        cfg_dst_i   = dst;
        cfg_cnt_i   = cnt;
        for (int t = 0; t < 200 && !hs; t++) begin
            @(negedge clk);
            hs = cfg_ready_o;
            @(posedge clk);
            #1;
        end
        cfg_valid_i = 1'b0;
        cur_tag     = cnt;
        if (!hs) chk("cfg_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_rows(input int n, input int bad);
        for (int i = 0; i < n; i++) begin
            logic hs = 1'b0;
            row_valid_i = 1'b1;
            row_data_i  = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
            row_cnt_i   = (i == bad) ? cur_tag + 8'd1 : cur_tag;
            for (int t = 0; t < 200 && !hs; t++) begin
                @(negedge clk);
                hs = row_ready_o;
                @(posedge clk);
                #1;
            end
            if (!hs) begin
                chk("row_timeout", 1'b0, 1'b1);
                row_valid_i = 1'b0;
                return;
            end
        end
        row_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        logic seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            seen = cfg_ready_o;
        end
        if (!seen) chk("idle_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cfg_ready", cfg_ready_o, 1'b1);
        chk("rst_row_ready", row_ready_o, 1'b0);
        chk("rst_aw_valid", aw_valid_o, 1'b0);
        chk("rst_aw_addr", aw_addr_o, 64'h0);
        chk("rst_aw_data", aw_data_o, 256'h0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
    endtask

    initial begin
        int d0;
        n_run = 0; n_fail = 0; done_cnt = 0; cur_tag = 8'd0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;

        // Plain tile at full throughput.
        d0 = done_cnt;
        do_cfg(64'h1000, 8'd3);
        send_rows(16, -1);
        wait_idle();
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_aw_count", aw_log.size(), 16);
        chk("t1_first_addr", aw_log[0], 64'h1000);
        chk("t1_last_addr", aw_log[15], 64'h1F00);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Write channel stalled while rows keep arriving.
        d0 = done_cnt;
        aw_ready_i = 1'b0;
        do_cfg(64'h8000, 8'd3);
        fork
            send_rows(16, -1);
            begin
                repeat (10) @(negedge clk);
                chk("t2_pushes", tb_in, 4);
                chk("t2_row_ready", row_ready_o, 1'b0);
                chk("t2_aw_valid", aw_valid_o, 1'b1);
                chk("t2_aw_addr", aw_addr_o, 64'h8000);
                @(posedge clk); #1;
                aw_ready_i = 1'b1;
            end
        join
        wait_idle();
        chk("t2_done_cnt", done_cnt - d0, 1);
        chk("t2_aw_count", aw_log.size(), 16);
        chk("t2_sb_empty", exp_q.size(), 0);

        // Address wrap-around.
        d0 = done_cnt;
        do_cfg(64'hFFFF_FFFF_FFFF_FF00, 8'd3);
        send_rows(16, -1);
        wait_idle();
        chk("t3_row0_addr", aw_log[0], 64'hFFFF_FFFF_FFFF_FF00);
        chk("t3_row1_addr", aw_log[1], 64'h0);
        chk("t3_row15_addr", aw_log[15], 64'hE00);
        chk("t3_done_cnt", done_cnt - d0, 1);

        // cfg offered mid-tile, then a 17th row.
        d0 = done_cnt;
        do_cfg(64'h4000, 8'd3);
        cfg_valid_i = 1'b1;
        cfg_dst_i   = 64'h9000;
        repeat (3) begin
            @(negedge clk);
            chk("t4_cfg_ready", cfg_ready_o, 1'b0);
        end
        @(posedge clk); #1;
        cfg_valid_i = 1'b0;
        send_rows(16, -1);
        row_valid_i = 1'b1;
        begin
            int idle_seen = 0;
            for (int t = 0; t < 100 && idle_seen < 3; t++) begin
                @(negedge clk);
                chk("t4_row17_ready", row_ready_o, 1'b0);
                if (cfg_ready_o) idle_seen++;
            end
            if (idle_seen < 3) chk("t4_idle_timeout", 1'b0, 1'b1);
        end
        @(posedge clk); #1;
        row_valid_i = 1'b0;
        chk("t4_base_kept", aw_log[0], 64'h4000);
        chk("t4_aw_count", aw_log.size(), 16);
        chk("t4_done_cnt", done_cnt - d0, 1);

        // Reset in the middle of a tile.
        d0 = done_cnt;
        do_cfg(64'h6000, 8'd3);
        send_rows(7, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        repeat (5) @(negedge clk);
        chk("t5_no_done", done_cnt - d0, 0);
        @(posedge clk); #1;
        do_cfg(64'h2000, 8'd3);
        send_rows(16, -1);
        wait_idle();
        chk("t5_restart_addr", aw_log[0], 64'h2000);
        chk("t5_done_cnt", done_cnt - d0, 1);

        // Tag mismatch on row 5.
        do_cfg(64'h3000, 8'd3);
        send_rows(5, -1);
        @(negedge clk);
        chk("t6_err_before", err_o, 1'b0);
        @(posedge clk); #1;
        send_rows(1, 0);
        @(negedge clk);
        chk("t6_err_set", err_o, EXP_ERR);
        @(posedge clk); #1;
        send_rows(10, -1);
        wait_idle();
        chk("t6_err_sticky", err_o, EXP_ERR);
        chk("t6_row5_addr", aw_log[5], 64'h3500);
        chk("t6_aw_count", aw_log.size(), 16);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
